// File: rtl/apb_uart_host.sv
// apb_uart_host
// APB4 initiator for the UART register port. Commands arrive on a valid/ready
// port and are queued in a small FIFO. Each command becomes one APB
// setup+access transfer. The result comes back on a valid/ready response port.
// A watchdog ends any transfer whose pready never arrives.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake (ready = FIFO not full)
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_strb_i    command payload (1 = write, 0 = read)
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o                read data (0 for writes and timeouts)
//   rsp_slverr_o               pslverr sampled on completion
//   rsp_timeout_o              transfer ended by the watchdog
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o, pstrb_o APB request (all registered)
//   prdata_i, pready_i,
//   pslverr_i                  APB completion
//   busy_o                     FIFO non-empty or transfer/response in progress
module apb_uart_host #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_slverr_o,
  output logic                rsp_timeout_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i,
  output logic                busy_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WD_W   = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             push;
  logic             pop;
  cmd_t             head;
  cmd_t             cmd_in;

  assign push   = cmd_valid_i && cmd_ready_q;
  assign head   = mem_q[rd_ptr_q];
  assign cmd_in = '{write: cmd_write_i, addr: cmd_addr_i,
                    wdata: cmd_wdata_i, strb: cmd_strb_i};

  // NOTE: storage is not reset; count_q gates every read, so stale entries are
  // never observed and the array maps onto plain flops or RAM without a reset net.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM and registered outputs
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_slverr_q, rsp_slverr_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              busy_q, busy_d;
  logic              launch;
  logic              end_xfer;

  // NOTE: every variable gets its default before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    launch        = 1'b0;
    end_xfer      = 1'b0;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        launch = (count_q != '0);
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (pready_i) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
          rsp_slverr_d  = pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          end_xfer      = 1'b1;
          state_d       = RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
          // This is the TIMEOUT-th ACCESS cycle without pready.
          if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b0;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            end_xfer      = 1'b1;
            state_d       = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          // Chain straight into the next transfer, skipping IDLE.
          launch      = (count_q != '0);
        end
      end

      default: state_d = IDLE;
    endcase

    if (end_xfer) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
      pstrb_d   = '0;
    end

    if (launch) begin
      pop       = 1'b1;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = head.write;
      paddr_d   = head.addr;
      // Reads drive neither data nor strobes.
      pwdata_d  = head.write ? head.wdata : '0;
      pstrb_d   = head.write ? head.strb  : '0;
      wdog_d    = '0;
      state_d   = SETUP;
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    // Ready follows the registered fill level, so a full FIFO refuses a push
    // even in a cycle where the head is popped.
    cmd_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wdog_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_slverr_o  = rsp_slverr_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_apb_uart_host.sv
// tb_apb_uart_host
// Directed self-checking bench for apb_uart_host (default parameters). A small
// APB slave model answers after a programmable number of wait states, or
// never while stall is set. Outputs are sampled 1 time unit after the edge.
module tb_apb_uart_host;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Slave model controls.
  logic              stall         = 1'b0;
  int                ws            = 0;
  logic [DATA_W-1:0] prdata_v      = '0;
  logic              use_addr_data = 1'b0;
  logic              pslverr_v     = 1'b0;
  int                acc_cnt       = 0;

  always #5 clk = ~clk;

  apb_uart_host dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_strb_i    (cmd_strb),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_slverr_o  (rsp_slverr),
    .rsp_timeout_o (rsp_timeout),
    .psel_o        (psel),
    .penable_o     (penable),
    .pwrite_o      (pwrite),
    .paddr_o       (paddr),
    .pwdata_o      (pwdata),
    .pstrb_o       (pstrb),
    .prdata_i      (prdata),
    .pready_i      (pready),
    .pslverr_i     (pslverr),
    .busy_o        (busy)
  );

  // acc_cnt = ACCESS cycles already spent in the current transfer.
  assign pready  = penable && !stall && (acc_cnt >= ws);
  assign prdata  = use_addr_data ? {8'hAB, 16'h0000, paddr} : prdata_v;
  assign pslverr = pslverr_v;

  always @(posedge clk) begin
    if (!penable || pready) acc_cnt <= 0;
    else                    acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command; returns 1 unit after the accepting edge.
  task automatic push(input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    int n = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("push_ready_wait", {63'd0, cmd_ready}, 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 60) begin
      step();
      n++;
    end
    check(tag, {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int psel_cnt;

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;

    // ---- Reset state ----
    check("rst_apb_ctrl", {61'd0, psel, penable, pwrite}, 64'd0);
    check("rst_apb_data", {paddr, pwdata, pstrb}, 64'd0);
    check("rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    step();
    step();
    rst_n = 1'b1;

    // ---- 1: single write, zero wait states ----
    push(1'b1, 8'h0C, 32'hA5A5_1234, 4'hF);                       // E0
    check("t1_e0_psel", {63'd0, psel}, 64'd0);
    check("t1_e0_busy", {63'd0, busy}, 64'd1);
    step();                                                          // E1
    check("t1_e1_ctrl", {61'd0, psel, penable, pwrite}, 64'b101);
    check("t1_e1_paddr", {56'd0, paddr}, 64'h0C);
    check("t1_e1_pwdata", {32'd0, pwdata}, 64'hA5A5_1234);
    check("t1_e1_pstrb", {60'd0, pstrb}, 64'hF);
    step();                                                          // E2
    check("t1_e2_ctrl", {61'd0, psel, penable, pwrite}, 64'b111);
    step();                                                          // E3
    check("t1_e3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("t1_e3_apb_idle", {62'd0, psel, penable}, 64'd0);
    check("t1_e3_rsp", {rsp_slverr, rsp_timeout, rsp_rdata}, 64'd0);
    check("t1_e3_apb_cleared", {pwrite, paddr, pwdata, pstrb}, 64'd0);
    handshake();
    check("t1_rsp_dropped", {63'd0, rsp_valid}, 64'd0);
    check("t1_idle_busy", {63'd0, busy}, 64'd0);

    // ---- 2: read with 3 wait states ----
    ws       = 3;
    prdata_v = 32'h0000_0055;
    push(1'b0, 8'h04, 32'hDEAD_BEEF, 4'hF);
    step();
    check("t2_e1_ctrl", {61'd0, psel, penable, pwrite}, 64'b100);
    check("t2_e1_paddr", {56'd0, paddr}, 64'h04);
    check("t2_read_wdata_strb", {28'd0, pwdata, pstrb}, 64'd0);
    step();
    n = 0;
    while (penable && n < 40) begin
      n++;
      step();
    end
    check("t2_penable_cycles", 64'(n), 64'd4);
    check("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("t2_rdata", {32'd0, rsp_rdata}, 64'h55);
    check("t2_flags", {62'd0, rsp_slverr, rsp_timeout}, 64'd0);
    handshake();
    check("t2_rsp_dropped", {63'd0, rsp_valid}, 64'd0);

    // ---- 3: five back-to-back pushes, FIFO fills, order preserved ----
    ws            = 2;
    use_addr_data = 1'b1;
    rsp_ready     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 8'(8'h10 + 4 * i), '0, '0);
      check($sformatf("t3_cmd_ready_%0d", i), {63'd0, cmd_ready}, (i < 4) ? 64'd1 : 64'd0);
    end
    step();
    check("t3_still_full", {63'd0, cmd_ready}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      wait_rsp($sformatf("t3_rsp_wait_%0d", k));
      check($sformatf("t3_rdata_%0d", k), {32'd0, rsp_rdata},
            {32'd0, 8'hAB, 16'h0000, 8'(8'h10 + 4 * k)});
      step();
      if (k < 4) check($sformatf("t3_next_setup_%0d", k), {62'd0, psel, penable}, 64'b10);
      else       check("t3_last_psel", {62'd0, psel, penable}, 64'd0);
    end
    check("t3_drained_busy", {63'd0, busy}, 64'd0);
    rsp_ready     = 1'b0;
    use_addr_data = 1'b0;
    ws            = 0;

    // ---- 4: watchdog timeout, then next command proceeds ----
    stall     = 1'b1;
    pslverr_v = 1'b1;
    prdata_v  = 32'h0000_1234;
    push(1'b0, 8'h20, '0, '0);
    push(1'b1, 8'h24, 32'h1122_3344, 4'h3);
    check("t4_setup", {62'd0, psel, penable}, 64'b10);
    step();
    n = 0;
    while (penable && n < 40) begin
      n++;
      step();
    end
    check("t4_access_cycles", 64'(n), 64'd16);
    check("t4_psel_dropped", {63'd0, psel}, 64'd0);
    check("t4_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("t4_timeout_rsp", {rsp_slverr, rsp_timeout, rsp_rdata}, {30'd0, 2'b01, 32'd0});
    stall     = 1'b0;
    pslverr_v = 1'b0;
    handshake();
    check("t4_next_setup", {55'd0, psel, pwrite, paddr}, {55'd0, 2'b11, 8'h24});
    check("t4_next_pwdata", {28'd0, pwdata, pstrb}, {28'd0, 32'h1122_3344, 4'h3});
    wait_rsp("t4_next_rsp_wait");
    check("t4_next_rsp", {rsp_slverr, rsp_timeout, rsp_rdata}, 64'd0);
    handshake();

    // ---- 5: slave error, response held with no new transfer ----
    pslverr_v = 1'b1;
    push(1'b1, 8'h08, 32'hCAFE_F00D, 4'hF);
    push(1'b0, 8'h0C, '0, '0);
    wait_rsp("t5_rsp_wait");
    check("t5_slverr", {62'd0, rsp_slverr, rsp_timeout}, 64'b10);
    pslverr_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t5_hold_%0d", i), {62'd0, rsp_valid, psel}, 64'b10);
    end
    handshake();
    check("t5_after_hs", {55'd0, rsp_valid, psel, paddr}, {55'd0, 2'b01, 8'h0C});
    wait_rsp("t5_second_wait");
    check("t5_second_rsp", {rsp_slverr, rsp_timeout, rsp_rdata}, {32'd0, 32'h0000_1234});
    handshake();

    // ---- 6: asynchronous reset mid-ACCESS with two queued ----
    stall = 1'b1;
    push(1'b1, 8'h30, 32'h1, 4'h1);
    push(1'b1, 8'h34, 32'h2, 4'h2);
    push(1'b1, 8'h38, 32'h3, 4'h4);
    step();
    check("t6_in_access", {62'd0, psel, penable}, 64'b11);
    #3 rst_n = 1'b0;
    #1;
    check("t6_apb_ctrl", {61'd0, psel, penable, pwrite}, 64'd0);
    check("t6_apb_data", {paddr, pwdata, pstrb}, 64'd0);
    check("t6_ready_busy_valid", {61'd0, cmd_ready, busy, rsp_valid}, 64'b100);
    step();
    rst_n = 1'b1;
    stall = 1'b0;
    psel_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (psel) psel_cnt++;
    end
    check("t6_no_resume", 64'(psel_cnt), 64'd0);
    check("t6_busy_after", {62'd0, busy, rsp_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_uart_host.md
Name: apb_uart_host

Overview:
APB4 initiator that drives register accesses into the UART's APB slave port. It accepts write/read commands on a valid/ready command port and buffers them in a small FIFO. Each command becomes one APB setup+access transfer, and the result is returned on a valid/ready response port. A watchdog ends any transfer whose pready never arrives. The block sits between bench/firmware-model traffic and the UART register interface.

Parameters:
ADDR_W, 8, paddr width
DATA_W, 32, pwdata/prdata width; strobe width is DATA_W/8
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, max ACCESS cycles waiting for pready (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_slverr  out  1  pslverr sampled at completion
rsp_timeout  out  1  transfer ended by watchdog
psel, penable, pwrite  out  1 each  APB control
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): every output is 0 except cmd_ready=1. FIFO is emptied, FSM goes to IDLE, watchdog clears. A reset during an in-flight transfer drops psel/penable immediately. The pending response and all queued commands are discarded.
- All outputs are registered.
- Command FIFO: push on cmd_valid&&cmd_ready. cmd_ready=0 when full, even if a pop happens in the same cycle. Pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if FIFO non-empty, pop head, load paddr/pwrite/pwdata/pstrb, set psel=1, go to SETUP. For reads, pwdata=0 and pstrb=0.
- SETUP: lasts exactly one cycle. Set penable=1, go to ACCESS.
- ACCESS: paddr/pwrite/pwdata/pstrb stay stable.
  - pready=1: capture rsp_rdata (prdata for reads, 0 for writes) and rsp_slverr=pslverr; set rsp_timeout=0; drop psel and penable; assert rsp_valid; go to RESP.
  - pready=0: watchdog increments. When it has counted TIMEOUT cycles without pready, drop psel and penable; set rsp_timeout=1, rsp_slverr=0, rsp_rdata=0; go to RESP.
- RESP: rsp_* hold until rsp_ready=1. On the handshake cycle, rsp_valid drops.
  - If the FIFO is non-empty, pop and go to SETUP directly, with psel=1 on the next edge.
  - Otherwise go to IDLE.
- After a transfer ends, paddr/pwdata/pstrb/pwrite return to 0.
- Latency: command accepted at edge E0 into an empty FIFO in IDLE gives psel=1 from E1 and penable=1 from E2. If pready=1 in the E2-E3 cycle, then from E3: rsp_valid=1, psel=0, penable=0. Minimum 3 cycles from accept to response.
- Watchdog: resets to 0 on each SETUP entry. Width is clog2(TIMEOUT)+1.
- At most one transfer and one response are outstanding. A new APB transfer never starts while rsp_valid=1.
- busy=1 whenever FSM!=IDLE or FIFO non-empty.

Test Plan:
1. Write addr 0x0C, data 0xA5A5_1234, strb 0xF, pready tied 1 -> psel at E1, penable at E2, paddr=0x0C, pwdata=0xA5A51234, pstrb=0xF. rsp_valid at E3 with rdata=0, slverr=0, timeout=0.
2. Read addr 0x04, slave inserts 3 wait states, prdata=0x0000_0055 -> penable high for 4 cycles, pwdata=0, pstrb=0. rsp_rdata=0x55.
3. Push 5 commands back-to-back with rsp_ready=1 and slave stalling the first transfer -> cmd_ready=0 after 4 entries are queued (head popped). Five APB transfers follow in push order. Each new SETUP starts the cycle after its response handshake.
4. pready held 0 -> psel/penable drop after exactly 16 ACCESS cycles. Response has timeout=1, slverr=0, rdata=0. The next queued command then proceeds normally.
5. pslverr=1 with pready=1 on a write -> rsp_slverr=1. rsp_valid is held 5 cycles with rsp_ready=0 and no new psel meanwhile.
6. rst_n pulsed low mid-ACCESS with 2 commands queued -> outputs 0 asynchronously, cmd_ready=1, busy=0. No transfer resumes after release.
